// File: rtl/multisim_serializer_pkg.sv
// Shared definitions for multisim_push_serializer.
//   state_e              : serializer states (IDLE, HEADER, SEND)
//   HDR_*                : bit placement of the header beat fields
//   num_beats(msg, data) : beats needed to carry one message
package multisim_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    SEND   = 2'd2
  } state_e;

  localparam int HDR_BEATS_LSB = 0;
  localparam int HDR_SEQ_LSB   = 16;
  localparam int HDR_FIELD_W   = 16;

  function automatic int num_beats(input int msg_w, input int data_w);
    return (msg_w + data_w - 1) / data_w;
  endfunction

endpackage

// File: rtl/multisim_push_serializer.sv
// multisim_push_serializer: splits one MSG_WIDTH-bit message into
// DATA_WIDTH-bit beats, least-significant beat first.
//
// Ports:
//   clk      : sole clock, rising edge
//   rst      : asynchronous active-high reset
//   in_vld   : message valid
//   in_rdy   : serializer can accept a message (0 while rst=1)
//   in_data  : message payload, sampled on in_vld && in_rdy
//   out_vld  : beat valid (to push client data_vld)
//   out_rdy  : beat accepted (from push client data_rdy)
//   out_data : current beat, 0 whenever out_vld=0
//   busy     : high from message acceptance until the last beat handshakes
//
// Handshake: a transfer happens on a rising edge where vld && rdy. Once
// out_vld rises it stays high, with out_data stable, until that edge.
//
// Macro MULTISIM_SERIALIZER_HEADER_EN: when defined, every message is
// preceded by a header beat {seq[15:0], NUM_BEATS[15:0]}.
module multisim_push_serializer
  import multisim_serializer_pkg::*;
#(
  parameter int MSG_WIDTH  = 256,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [MSG_WIDTH-1:0]  in_data,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy
);

  localparam int NUM_BEATS = num_beats(MSG_WIDTH, DATA_WIDTH);
  localparam int CNT_W     = $clog2(NUM_BEATS + 1);
  // The message register is padded to a whole number of beats so the
  // final beat reads zeros above MSG_WIDTH without extra masking.
  localparam int PAD_W     = NUM_BEATS * DATA_WIDTH;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  localparam logic [1:0] ST_IDLE   = 2'(IDLE);
  localparam logic [1:0] ST_SEND   = 2'(SEND);
`ifdef MULTISIM_SERIALIZER_HEADER_EN
  localparam logic [1:0] ST_HEADER = 2'(HEADER);
`endif

  logic [1:0]            state;
  logic [CNT_W-1:0]      beat_cnt;
  logic [PAD_W-1:0]      msg_q;
  logic [DATA_WIDTH-1:0] beat_data;

  assign beat_data = msg_q[int'(beat_cnt) * DATA_WIDTH +: DATA_WIDTH];

`ifdef MULTISIM_SERIALIZER_HEADER_EN
  logic [HDR_FIELD_W-1:0] seq_q;
  logic [DATA_WIDTH-1:0]  hdr_data;

  if (DATA_WIDTH < 32) begin : g_hdr_width_check
    $error("multisim_push_serializer: header needs DATA_WIDTH >= 32");
  end

  always_comb begin
    hdr_data = '0;
    hdr_data[HDR_BEATS_LSB +: HDR_FIELD_W] = HDR_FIELD_W'(NUM_BEATS);
    hdr_data[HDR_SEQ_LSB +: HDR_FIELD_W]   = seq_q;
  end
`endif

  // Outputs decode straight from state so reset clears them asynchronously.
  always_comb begin
    in_rdy   = !rst && (state == ST_IDLE);
    busy     = (state != ST_IDLE);
    out_vld  = (state == ST_SEND);
    out_data = '0;
    if (state == ST_SEND) out_data = beat_data;
`ifdef MULTISIM_SERIALIZER_HEADER_EN
    if (state == ST_HEADER) begin
      out_vld  = 1'b1;
      out_data = hdr_data;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      msg_q    <= '0;
`ifdef MULTISIM_SERIALIZER_HEADER_EN
      seq_q    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_vld && in_rdy) begin
            msg_q    <= PAD_W'(in_data);
            beat_cnt <= '0;
`ifdef MULTISIM_SERIALIZER_HEADER_EN
            state    <= ST_HEADER;
`else
            state    <= ST_SEND;
`endif
          end
        end
`ifdef MULTISIM_SERIALIZER_HEADER_EN
        ST_HEADER: begin
          if (out_rdy) begin
            seq_q    <= seq_q + 1'b1;
            beat_cnt <= '0;
            state    <= ST_SEND;
          end
        end
`endif
        ST_SEND: begin
          if (out_rdy) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              state    <= ST_IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multisim_push_serializer.sv
module tb_multisim_push_serializer;

  localparam int AW   = 256;
  localparam int BW   = 100;
  localparam int DW   = 64;
  localparam int A_NB = 4;
  localparam int B_NB = 2;
`ifdef MULTISIM_SERIALIZER_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT a: 256/64 (4 beats), DUT b: 100/64 (2 beats, padded)
  logic          a_in_vld, a_in_rdy, a_out_vld, a_out_rdy, a_busy;
  logic [AW-1:0] a_in_data;
  logic [DW-1:0] a_out_data;
  logic          b_in_vld, b_in_rdy, b_out_vld, b_out_rdy, b_busy;
  logic [BW-1:0] b_in_data;
  logic [DW-1:0] b_out_data;

  multisim_push_serializer #(.MSG_WIDTH(AW), .DATA_WIDTH(DW)) dut_a (
    .clk(clk), .rst(rst), .in_vld(a_in_vld), .in_rdy(a_in_rdy),
    .in_data(a_in_data), .out_vld(a_out_vld), .out_rdy(a_out_rdy),
    .out_data(a_out_data), .busy(a_busy)
  );

  multisim_push_serializer #(.MSG_WIDTH(BW), .DATA_WIDTH(DW)) dut_b (
    .clk(clk), .rst(rst), .in_vld(b_in_vld), .in_rdy(b_in_rdy),
    .in_data(b_in_data), .out_vld(b_out_vld), .out_rdy(b_out_rdy),
    .out_data(b_out_data), .busy(b_busy)
  );

  // ---------------- scoreboard state ----------------
  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;
  bit            rand_rdy = 1'b0;
  logic [DW-1:0] exp_a[$];
  logic [DW-1:0] exp_b[$];
  logic [15:0]   seq_a, seq_b;
  bit            a_stall, b_stall;
  logic [DW-1:0] a_held, b_held;
  int            acc_cyc;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference model: a message becomes an optional header then its value
  // shifted down one beat width at a time.
  task automatic push_a(input logic [AW-1:0] m);
    if (HDR != 0) begin
      exp_a.push_back(DW'({seq_a, 16'(A_NB)}));
      seq_a++;
    end
    for (int i = 0; i < A_NB; i++) exp_a.push_back(DW'(m >> (DW * i)));
  endtask

  task automatic push_b(input logic [BW-1:0] m);
    if (HDR != 0) begin
      exp_b.push_back(DW'({seq_b, 16'(B_NB)}));
      seq_b++;
    end
    for (int i = 0; i < B_NB; i++) exp_b.push_back(DW'(m >> (DW * i)));
  endtask

  // Observes both output ports on the falling edge.
  task automatic monitor_all();
    if (a_stall) begin
      chk_b("a_hold_vld", a_out_vld, 1'b1);
      chk("a_hold_data", a_out_data, a_held);
    end
    if (!a_out_vld) chk("a_idle_zero", a_out_data, '0);
    if (a_out_vld && a_out_rdy) begin
      checks++;
      assert (exp_a.size() > 0) else begin
        errors++;
        $error("FAIL a_extra_beat: observed %h expected none", a_out_data);
      end
      if (exp_a.size() > 0) chk("a_beat", a_out_data, exp_a.pop_front());
    end
    a_stall = a_out_vld && !a_out_rdy;
    a_held  = a_out_data;

    if (b_stall) begin
      chk_b("b_hold_vld", b_out_vld, 1'b1);
      chk("b_hold_data", b_out_data, b_held);
    end
    if (!b_out_vld) chk("b_idle_zero", b_out_data, '0);
    if (b_out_vld && b_out_rdy) begin
      checks++;
      assert (exp_b.size() > 0) else begin
        errors++;
        $error("FAIL b_extra_beat: observed %h expected none", b_out_data);
      end
      if (exp_b.size() > 0) chk("b_beat", b_out_data, exp_b.pop_front());
    end
    b_stall = b_out_vld && !b_out_rdy;
    b_held  = b_out_data;
  endtask

  // One clock cycle: check at negedge, then step past the rising edge.
  task automatic tick();
    @(negedge clk);
    monitor_all();
    @(posedge clk);
    cyc++;
    #1;
    if (rand_rdy) begin
      a_out_rdy = 1'($urandom_range(0, 1));
      b_out_rdy = 1'($urandom_range(0, 1));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_a(input logic [AW-1:0] m);
    int guard = 0;
    while (!a_in_rdy && guard < 200) begin tick(); guard++; end
    checks++;
    assert (a_in_rdy) else begin
      errors++;
      $error("FAIL a_in_rdy_timeout: observed 0 expected 1");
    end
    a_in_vld  = 1'b1;
    a_in_data = m;
    tick();
    push_a(m);
    acc_cyc   = cyc;
    a_in_vld  = 1'b0;
  endtask

  task automatic send_b(input logic [BW-1:0] m);
    int guard = 0;
    while (!b_in_rdy && guard < 200) begin tick(); guard++; end
    checks++;
    assert (b_in_rdy) else begin
      errors++;
      $error("FAIL b_in_rdy_timeout: observed 0 expected 1");
    end
    b_in_vld  = 1'b1;
    b_in_data = m;
    tick();
    push_b(m);
    b_in_vld  = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_a.size() > 0 || exp_b.size() > 0) && guard < 2000) begin
      tick(); guard++;
    end
    checks++;
    assert (exp_a.size() == 0 && exp_b.size() == 0) else begin
      errors++;
      $error("FAIL drain_timeout: observed %0d/%0d pending expected 0/0",
             exp_a.size(), exp_b.size());
    end
  endtask

  function automatic logic [AW-1:0] rnd_a();
    logic [AW-1:0] r;
    for (int i = 0; i < AW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    logic [AW-1:0] m, m2;
    logic [DW-1:0] basic[4];
    int            t0;

    rst = 1'b1;
    a_in_vld = 1'b0; a_in_data = '0; a_out_rdy = 1'b0;
    b_in_vld = 1'b0; b_in_data = '0; b_out_rdy = 1'b0;
    seq_a = '0; seq_b = '0; a_stall = 1'b0; b_stall = 1'b0;
    a_held = '0; b_held = '0; acc_cyc = 0;

    // reset values
    #12;
    chk_b("rst_in_rdy", a_in_rdy, 1'b0);
    chk_b("rst_out_vld", a_out_vld, 1'b0);
    chk("rst_out_data", a_out_data, '0);
    chk_b("rst_busy", a_busy, 1'b0);
    chk_b("rst_b_in_rdy", b_in_rdy, 1'b0);
    @(negedge clk); #1 rst = 1'b0;
    #1;
    chk_b("post_rst_in_rdy", a_in_rdy, 1'b1);
    chk_b("post_rst_busy", a_busy, 1'b0);
    @(posedge clk); #1;

    // basic split with out_rdy held high
    a_out_rdy = 1'b1;
    basic[0] = 64'h1111_1111_1111_1111;
    basic[1] = 64'h2222_2222_2222_2222;
    basic[2] = 64'h3333_3333_3333_3333;
    basic[3] = 64'h4444_4444_4444_4444;
    m = {basic[3], basic[2], basic[1], basic[0]};
    send_a(m);
`ifdef MULTISIM_SERIALIZER_HEADER_EN
    chk_b("basic_hdr_vld", a_out_vld, 1'b1);
    chk("basic_hdr_data", a_out_data, 64'h0000_0000_0000_0004);
    tick();
`endif
    for (int i = 0; i < 4; i++) begin
      chk_b("basic_vld", a_out_vld, 1'b1);
      chk("basic_beat", a_out_data, basic[i]);
      chk_b("basic_busy", a_busy, 1'b1);
      chk_b("basic_in_rdy_low", a_in_rdy, 1'b0);
      tick();
    end
    chk_b("basic_in_rdy_back", a_in_rdy, 1'b1);
    chk_b("basic_busy_done", a_busy, 1'b0);
    drain();

    // backpressure: hold out_rdy low for 5 cycles while beat 2 is shown
    m = rnd_a();
    send_a(m);
    for (int i = 0; i < HDR + 2; i++) tick();
    a_out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_b("bp_vld", a_out_vld, 1'b1);
      chk("bp_beat2", a_out_data, DW'(m >> (2 * DW)));
      chk_b("bp_in_rdy", a_in_rdy, 1'b0);
    end
    a_out_rdy = 1'b1;
    drain();

    // in_vld pulsed while busy must not be captured
    m  = rnd_a();
    m2 = rnd_a();
    send_a(m);
    a_in_vld  = 1'b1;
    a_in_data = m2;
    tick();
    chk_b("ign_in_rdy", a_in_rdy, 1'b0);
    chk_b("ign_busy", a_busy, 1'b1);
    tick();
    a_in_vld = 1'b0;
    drain();
    for (int i = 0; i < 3; i++) tick();
    chk_b("ign_idle_busy", a_busy, 1'b0);
    chk_b("ign_idle_vld", a_out_vld, 1'b0);

    // reset after beat 1 handshakes
    m = rnd_a();
    send_a(m);
    for (int i = 0; i < HDR + 2; i++) tick();
    #2 rst = 1'b1;
    #1;
    chk_b("mid_rst_vld", a_out_vld, 1'b0);
    chk("mid_rst_data", a_out_data, '0);
    chk_b("mid_rst_busy", a_busy, 1'b0);
    chk_b("mid_rst_in_rdy", a_in_rdy, 1'b0);
    exp_a.delete(); exp_b.delete();
    seq_a = '0; seq_b = '0;
    a_stall = 1'b0; b_stall = 1'b0;
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    m = rnd_a();
    send_a(m);
`ifdef MULTISIM_SERIALIZER_HEADER_EN
    tick();
`endif
    chk("post_rst_beat0", a_out_data, DW'(m));
    drain();

    // padding on the 100-bit instance
    b_out_rdy = 1'b1;
    send_b({BW{1'b1}});
`ifdef MULTISIM_SERIALIZER_HEADER_EN
    tick();
`endif
    chk("pad_beat0", b_out_data, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk("pad_beat1", b_out_data, 64'h0000_000F_FFFF_FFFF);
    tick();
    chk_b("pad_in_rdy", b_in_rdy, 1'b1);
    drain();

    // throughput: back-to-back messages with out_rdy high
    send_a(rnd_a());
    t0 = acc_cyc;
    send_a(rnd_a());
    chk("throughput", DW'(acc_cyc - t0), DW'(A_NB + HDR + 1));
    drain();

    // randomized traffic with random backpressure on both instances
    rand_rdy = 1'b1;
    for (int n = 0; n < 20; n++) begin
      send_a(rnd_a());
      send_b(BW'(rnd_a()));
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
    end
    drain();
    rand_rdy  = 1'b0;
    a_out_rdy = 1'b1;
    b_out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk_b("end_busy_a", a_busy, 1'b0);
    chk_b("end_busy_b", b_busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
